// File: rtl/axis_frame_len_limit_pkg.sv
// Shared definitions for the AXI-Stream frame length limiter.
package axis_frame_len_limit_pkg;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    // Bit of tuser that flags a truncated frame on its final emitted beat.
    localparam int USER_ERR_BIT = 0;

    // Widest tkeep the popcount helper handles; callers zero-extend.
    localparam int MAX_KEEP_WIDTH = 128;

    // Number of valid bytes in a beat.
    function automatic int unsigned popcount(input logic [MAX_KEEP_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_KEEP_WIDTH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_frame_len_limit_if.sv
// AXI-Stream bundle used for both the input and output ports of the limiter.
interface axis_frame_len_limit_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: output register plus one overflow slot.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;

    // Ready only while the overflow slot is free, so it never depends on out_ready.
    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Refill the output register from the skid slot first, else straight from the input.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // Occupancy flags; these alone are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Payload registers; contents are don't-care while the matching valid is low.
    always_ff @(posedge clk) begin
        out_data_q  <= out_data_d;
        skid_data_q <= skid_data_d;
    end
endmodule

// File: rtl/axis_frame_len_limit.sv
// Per-frame byte limiter: truncates over-long frames, drops their tail, keeps statistics.
module axis_frame_len_limit
    import axis_frame_len_limit_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_WIDTH  = DATA_WIDTH/8,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int LEN_WIDTH   = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_frame_len_limit_if.slave  s_axis,
    axis_frame_len_limit_if.master m_axis,
    input  logic [LEN_WIDTH-1:0]   cfg_max_len,
    output logic [COUNT_WIDTH-1:0] stat_frame_count,
    output logic [COUNT_WIDTH-1:0] stat_trunc_count,
    output logic [LEN_WIDTH-1:0]   stat_last_len
);
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam int LAST_BIT      = ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH:0] v);
        return v[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : v[LEN_WIDTH-1:0];
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LEN_WIDTH-1:0]   limit_q, limit_d;
    logic                   in_frame_q, in_frame_d;
    logic [LEN_WIDTH-1:0]   last_len_q, last_len_d;
    logic [COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [COUNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;

    logic                     s_ready, s_fire, m_valid, m_fire;
    logic [LEN_WIDTH:0]       beat_bytes, run;
    logic [LEN_WIDTH-1:0]     cur_limit;
    logic                     over;
    logic                     fwd_last;
    logic [USER_WIDTH-1:0]    fwd_user;
    logic [PAYLOAD_WIDTH-1:0] sb_in_data, sb_out_data;
    logic                     sb_in_ready, sb_out_valid;

    // The first beat of a frame uses the live cfg value; later beats use the captured one.
    assign cur_limit  = in_frame_q ? limit_q : cfg_max_len;
    assign beat_bytes = (LEN_WIDTH+1)'(popcount(MAX_KEEP_WIDTH'(s_axis.tkeep)));
    assign run        = {1'b0, byte_cnt_q} + beat_bytes;
    assign over       = (cur_limit != '0) && (run > {1'b0, cur_limit});

    // DROP swallows beats without touching the buffer, so it never back-pressures.
    assign s_ready       = !rst && ((state_q == ST_DROP) || sb_in_ready);
    assign s_axis.tready = s_ready;
    assign s_fire        = s_axis.tvalid && s_ready;

    assign m_valid       = sb_out_valid && !rst;
    assign m_axis.tvalid = m_valid;
    assign m_fire        = m_valid && m_axis.tready;

    // Force tlast and the error flag on the beat that crosses the limit.
    always_comb begin
        fwd_last = s_axis.tlast;
        fwd_user = s_axis.tuser;
        if (over) begin
            fwd_last               = 1'b1;
            fwd_user[USER_ERR_BIT] = 1'b1;
        end
    end

    assign sb_in_data = {s_axis.tdata, s_axis.tkeep, fwd_last, s_axis.tid, s_axis.tdest, fwd_user};
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest, m_axis.tuser} = sb_out_data;

    axis_skid_buffer #(
        .WIDTH(PAYLOAD_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (sb_in_data),
        .in_valid (s_fire && (state_q == ST_PASS)),
        .in_ready (sb_in_ready),
        .out_data (sb_out_data),
        .out_valid(sb_out_valid),
        .out_ready(m_axis.tready)
    );

    // Byte counting, limit capture, PASS/DROP transitions and statistics.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        limit_d     = limit_q;
        in_frame_d  = in_frame_q;
        last_len_d  = last_len_q;
        frame_cnt_d = frame_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        if (m_fire && sb_out_data[LAST_BIT]) begin
            frame_cnt_d = sat_inc(frame_cnt_q);
        end
        if (s_fire) begin
            if (!in_frame_q) begin
                limit_d = cfg_max_len;
            end
            in_frame_d = !s_axis.tlast;
            byte_cnt_d = sat_len(run);
            if (s_axis.tlast) begin
                byte_cnt_d = '0;
                last_len_d = sat_len(run);
            end
            if (state_q == ST_PASS && over) begin
                trunc_cnt_d = sat_inc(trunc_cnt_q);
                if (!s_axis.tlast) begin
                    state_d = ST_DROP;
                end
            end
            if (state_q == ST_DROP && s_axis.tlast) begin
                state_d = ST_PASS;
            end
        end
    end

    // Control and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PASS;
            byte_cnt_q  <= '0;
            limit_q     <= '0;
            in_frame_q  <= 1'b0;
            last_len_q  <= '0;
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            limit_q     <= limit_d;
            in_frame_q  <= in_frame_d;
            last_len_q  <= last_len_d;
            frame_cnt_q <= frame_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign stat_frame_count = frame_cnt_q;
    assign stat_trunc_count = trunc_cnt_q;
    assign stat_last_len    = last_len_q;
endmodule

// File: tb/tb_axis_frame_len_limit.sv
// Testbench for axis_frame_len_limit: directed scenarios plus randomized back-pressure.
module tb_axis_frame_len_limit;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int LW = 16;
    localparam int CW = 32;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic [0:0]  user;
    } beat_t;

    typedef struct packed {
        beat_t       b;
        logic [15:0] cfg;
    } drv_t;

    typedef struct {
        logic  s_ready;
        bit    s_fire;
        bit    m_fire;
        bit    drop;
        int    occ;
        logic  m_valid;
        logic  m_ready;
        beat_t m_beat;
    } trace_t;

    logic clk = 1'b0;
    logic rst;
    logic [LW-1:0] cfg_max_len;
    logic [CW-1:0] stat_frame_count, stat_trunc_count;
    logic [LW-1:0] stat_last_len;

    always #5 clk = ~clk;

    axis_frame_len_limit_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) s_if ();
    axis_frame_len_limit_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) m_if ();

    axis_frame_len_limit #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(8), .DEST_WIDTH(8),
        .USER_WIDTH(1), .LEN_WIDTH(LW), .COUNT_WIDTH(CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .cfg_max_len     (cfg_max_len),
        .stat_frame_count(stat_frame_count),
        .stat_trunc_count(stat_trunc_count),
        .stat_last_len   (stat_last_len)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state (frame-level view of the rules).
    int    m_sum, m_lim;
    bit    m_inframe, m_drop;
    int    exp_frames, exp_trunc, exp_last_len;
    int    buf_in, buf_out;
    beat_t exp_q[$];
    beat_t got_q[$];
    drv_t  stim[$];
    trace_t trace[$];

    function automatic int pc(input logic [7:0] k);
        int n = 0;
        for (int i = 0; i < 8; i++) if (k[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_sum = 0; m_lim = 0; m_inframe = 0; m_drop = 0;
        exp_frames = 0; exp_trunc = 0; exp_last_len = 0;
        buf_in = 0; buf_out = 0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic observe();
        beat_t ib, ob;
        if (s_if.tvalid === 1'b1 && s_if.tready === 1'b1) begin
            ib.data = s_if.tdata; ib.keep = s_if.tkeep; ib.last = s_if.tlast;
            ib.id = s_if.tid; ib.dest = s_if.tdest; ib.user = s_if.tuser;
            if (!m_inframe) begin
                m_inframe = 1; m_lim = int'(cfg_max_len); m_sum = 0; m_drop = 0;
            end
            m_sum += pc(ib.keep);
            if (!m_drop) begin
                ob = ib;
                if (m_lim != 0 && m_sum > m_lim) begin
                    ob.last = 1'b1; ob.user[0] = 1'b1;
                    exp_trunc++;
                    m_drop = !ib.last;
                end
                exp_q.push_back(ob);
                buf_in++;
                if (ob.last) exp_frames++;
            end else if (ib.last) begin
                m_drop = 0;
            end
            if (ib.last) begin
                exp_last_len = (m_sum > 65535) ? 65535 : m_sum;
                m_inframe = 0;
            end
        end
        if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            ob.data = m_if.tdata; ob.keep = m_if.tkeep; ob.last = m_if.tlast;
            ob.id = m_if.tid; ob.dest = m_if.tdest; ob.user = m_if.tuser;
            got_q.push_back(ob);
            buf_out++;
        end
    endtask

    task automatic drive(input drv_t d);
        s_if.tvalid = 1'b1;
        s_if.tdata = d.b.data; s_if.tkeep = d.b.keep; s_if.tlast = d.b.last;
        s_if.tid = d.b.id; s_if.tdest = d.b.dest; s_if.tuser = d.b.user;
        cfg_max_len = d.cfg;
    endtask

    task automatic add_frame(input int nb, input logic [7:0] last_keep, input logic [15:0] cfg0, input logic [15:0] cfg1);
        drv_t d;
        for (int i = 0; i < nb; i++) begin
            d.b.data = {$urandom(), $urandom()};
            d.b.keep = (i == nb - 1) ? last_keep : 8'hFF;
            d.b.last = (i == nb - 1);
            d.b.id   = 8'($urandom());
            d.b.dest = 8'($urandom());
            d.b.user = 1'b0;
            d.cfg    = (i == 0) ? cfg0 : cfg1;
            stim.push_back(d);
        end
    endtask

    // Sends stim, captures outputs and a per-cycle trace; called at posedge+1.
    task automatic run_traffic(input bit rnd_ready, input int budget);
        int idx = 0;
        int cyc = 0;
        bit fin;
        trace_t t;
        exp_q.delete(); got_q.delete(); trace.delete();
        buf_in = 0; buf_out = 0;
        m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stim.size() > 0) drive(stim[0]); else s_if.tvalid = 1'b0;
        while (cyc < budget && !(idx >= stim.size() && buf_in == buf_out)) begin
            @(negedge clk);
            fin = (s_if.tvalid === 1'b1 && s_if.tready === 1'b1);
            t.s_ready = s_if.tready; t.s_fire = fin;
            t.m_fire = (m_if.tvalid === 1'b1 && m_if.tready === 1'b1);
            t.drop = m_drop; t.occ = buf_in - buf_out;
            t.m_valid = m_if.tvalid; t.m_ready = m_if.tready;
            t.m_beat = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser};
            trace.push_back(t);
            observe();
            @(posedge clk); #1;
            if (fin) idx++;
            if (idx < stim.size()) drive(stim[idx]); else s_if.tvalid = 1'b0;
            m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        if (cyc >= budget) begin
            checks++; failures++;
            $display("FAIL traffic_timeout sent=%0d of %0d emitted=%0d expected=%0d", idx, stim.size(), buf_out, buf_in);
        end
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b0;
        stim.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; s_if.tvalid = 1'b0; m_if.tready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tkeep = 8'h00;
        s_if.tdata = '0; s_if.tid = '0; s_if.tdest = '0; s_if.tuser = '0;
        m_if.tready = 1'b1; cfg_max_len = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL rst_m_tvalid got=%b want=0", m_if.tvalid); end
        checks++; if (s_if.tready !== 1'b0) begin failures++; $display("FAIL rst_s_tready got=%b want=0", s_if.tready); end
        checks++; if (stat_frame_count !== 0 || stat_trunc_count !== 0 || stat_last_len !== 0) begin
            failures++; $display("FAIL rst_stats got=%0d/%0d/%0d want=0/0/0", stat_frame_count, stat_trunc_count, stat_last_len);
        end
        rst = 1'b0; model_reset(); #1;
        checks++; if (s_if.tready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b want=1", s_if.tready); end
    endtask

    task automatic test_passthrough();
        int s_first = -1, m_first = -1, run_len = 0;
        do_reset();
        for (int f = 0; f < 3; f++) add_frame(3, 8'hFF, 16'd0, 16'd0);
        run_traffic(1'b0, 500);
        checks++; if (got_q.size() !== 9 || exp_q.size() !== 9) begin failures++; $display("FAIL pass_count got=%0d want=9 (model %0d)", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL pass_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        foreach (trace[i]) begin
            if (trace[i].s_fire && s_first < 0) s_first = i;
            if (trace[i].m_fire && m_first < 0) m_first = i;
        end
        checks++; if (m_first !== s_first + 1) begin failures++; $display("FAIL pass_latency got=%0d want=%0d", m_first, s_first + 1); end
        for (int i = (m_first < 0 ? 0 : m_first); i < trace.size() && trace[i].m_fire; i++) run_len++;
        checks++; if (run_len !== 9) begin failures++; $display("FAIL pass_bubbles contiguous=%0d want=9", run_len); end
        checks++; if (stat_frame_count !== 3) begin failures++; $display("FAIL pass_frame_count got=%0d want=3", stat_frame_count); end
        checks++; if (stat_last_len !== 24) begin failures++; $display("FAIL pass_last_len got=%0d want=24", stat_last_len); end
        checks++; if (stat_trunc_count !== 0) begin failures++; $display("FAIL pass_trunc got=%0d want=0", stat_trunc_count); end
    endtask

    task automatic test_truncate();
        do_reset();
        add_frame(4, 8'hFF, 16'd16, 16'd16);
        run_traffic(1'b0, 500);
        checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL trunc_count got=%0d want=3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL trunc_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() >= 3) begin
            checks++; if ({got_q[2].last, got_q[2].user[0]} !== 2'b11) begin
                failures++; $display("FAIL trunc_flags got=%b want=11", {got_q[2].last, got_q[2].user[0]});
            end
        end
        checks++; if (stat_trunc_count !== 1) begin failures++; $display("FAIL trunc_stat got=%0d want=1", stat_trunc_count); end
        checks++; if (stat_last_len !== 32) begin failures++; $display("FAIL trunc_last_len got=%0d want=32", stat_last_len); end
        add_frame(1, 8'hFF, 16'd16, 16'd16);
        run_traffic(1'b0, 500);
        checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL trunc_next_count got=%0d want=1", got_q.size()); end
        if (got_q.size() >= 1 && exp_q.size() >= 1) begin
            checks++; if (got_q[0] !== exp_q[0] || got_q[0].user[0] !== 1'b0) begin
                failures++; $display("FAIL trunc_next_beat got=%h want=%h", got_q[0], exp_q[0]);
            end
        end
        checks++; if (stat_last_len !== 8 || stat_frame_count !== 2) begin
            failures++; $display("FAIL trunc_next_stats got=%0d/%0d want=8/2", stat_last_len, stat_frame_count);
        end
    endtask

    task automatic test_exact_limit();
        do_reset();
        add_frame(3, 8'h0F, 16'd20, 16'd20);
        run_traffic(1'b0, 500);
        checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL exact_count got=%0d want=3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL exact_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() >= 3) begin
            checks++; if ({got_q[2].keep, got_q[2].last, got_q[2].user[0]} !== {8'h0F, 2'b10}) begin
                failures++; $display("FAIL exact_tail got=%h want=%h", {got_q[2].keep, got_q[2].last, got_q[2].user[0]}, {8'h0F, 2'b10});
            end
        end
        checks++; if (stat_trunc_count !== 0 || stat_last_len !== 20) begin
            failures++; $display("FAIL exact_stats got=%0d/%0d want=0/20", stat_trunc_count, stat_last_len);
        end
    endtask

    task automatic test_back_to_back_random();
        drv_t d;
        logic [15:0] cfg;
        int nb;
        logic exp_ready;
        do_reset();
        for (int f = 0; f < 30; f++) begin
            nb  = $urandom_range(1, 6);
            cfg = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            for (int i = 0; i < nb; i++) begin
                d.b.data = {$urandom(), $urandom()};
                d.b.keep = 8'($urandom());
                d.b.last = (i == nb - 1);
                d.b.id   = 8'($urandom());
                d.b.dest = 8'($urandom());
                d.b.user = 1'($urandom());
                d.cfg    = cfg;
                stim.push_back(d);
            end
        end
        run_traffic(1'b1, 5000);
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        foreach (trace[i]) begin
            exp_ready = trace[i].drop ? 1'b1 : (trace[i].occ < 2);
            checks++; if (trace[i].s_ready !== exp_ready) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b occ=%0d", i, trace[i].s_ready, exp_ready, trace[i].occ);
            end
        end
        for (int i = 1; i < trace.size(); i++) begin
            if (trace[i-1].m_valid === 1'b1 && trace[i-1].m_ready === 1'b0) begin
                checks++; if (trace[i].m_valid !== 1'b1 || trace[i].m_beat !== trace[i-1].m_beat) begin
                    failures++; $display("FAIL rand_stall cyc=%0d got=%h want=%h", i, trace[i].m_beat, trace[i-1].m_beat);
                end
            end
        end
        checks++; if (stat_frame_count !== CW'(exp_frames) || stat_trunc_count !== CW'(exp_trunc) || stat_last_len !== LW'(exp_last_len)) begin
            failures++; $display("FAIL rand_stats got=%0d/%0d/%0d want=%0d/%0d/%0d", stat_frame_count, stat_trunc_count, stat_last_len, exp_frames, exp_trunc, exp_last_len);
        end
    endtask

    task automatic test_cfg_change();
        do_reset();
        add_frame(3, 8'hFF, 16'd8, 16'd0);
        add_frame(3, 8'hFF, 16'd0, 16'd0);
        run_traffic(1'b0, 500);
        checks++; if (got_q.size() !== 5) begin failures++; $display("FAIL cfg_count got=%0d want=5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL cfg_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() >= 5) begin
            checks++; if ({got_q[1].last, got_q[1].user[0], got_q[4].last, got_q[4].user[0]} !== 4'b1110) begin
                failures++; $display("FAIL cfg_flags got=%b want=1110", {got_q[1].last, got_q[1].user[0], got_q[4].last, got_q[4].user[0]});
            end
        end
        checks++; if (stat_trunc_count !== 1 || stat_frame_count !== 2 || stat_last_len !== 24) begin
            failures++; $display("FAIL cfg_stats got=%0d/%0d/%0d want=1/2/24", stat_trunc_count, stat_frame_count, stat_last_len);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        add_frame(1, 8'hFF, 16'd0, 16'd0);
        add_frame(2, 8'hFF, 16'd0, 16'd0);
        void'(stim.pop_back());
        run_traffic(1'b0, 500);
        s_if.tvalid = 1'b1; s_if.tlast = 1'b0; s_if.tkeep = 8'hFF;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL mid_rst_tvalid got=%b want=0", m_if.tvalid); end
        checks++; if (s_if.tready !== 1'b0) begin failures++; $display("FAIL mid_rst_tready got=%b want=0", s_if.tready); end
        checks++; if (stat_frame_count !== 0 || stat_trunc_count !== 0 || stat_last_len !== 0) begin
            failures++; $display("FAIL mid_rst_stats got=%0d/%0d/%0d want=0/0/0", stat_frame_count, stat_trunc_count, stat_last_len);
        end
        rst = 1'b0; s_if.tvalid = 1'b0; model_reset(); #1;
        checks++; if (s_if.tready !== 1'b1) begin failures++; $display("FAIL mid_rst_release got=%b want=1", s_if.tready); end
        add_frame(2, 8'hFF, 16'd16, 16'd16);
        run_traffic(1'b0, 500);
        checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL mid_new_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i] || got_q[i].user[0] !== 1'b0) begin
                failures++; $display("FAIL mid_new_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        checks++; if (stat_frame_count !== 1 || stat_last_len !== 16 || stat_trunc_count !== 0) begin
            failures++; $display("FAIL mid_new_stats got=%0d/%0d/%0d want=1/16/0", stat_frame_count, stat_last_len, stat_trunc_count);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_truncate();
        test_exact_limit();
        test_back_to_back_random();
        test_cfg_change();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axis_frame_len_limit.md
Name: axis_frame_len_limit

Overview:
- Single-clock AXI-Stream stage placed directly downstream of the async FIFO master port, in the application clock domain.
- Counts bytes per frame. Forwards compliant frames unchanged.
- Truncates frames longer than a runtime limit: the offending beat is forced to tlast with an error flag, and the rest of that frame is discarded.
- Registered output through a skid buffer, which breaks timing between the FIFO read side and downstream logic. Exposes per-frame statistics.

Parameters:
- DATA_WIDTH, 64, tdata width in bits (multiple of 8)
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- ID_WIDTH, 8, tid width
- DEST_WIDTH, 8, tdest width
- USER_WIDTH, 1, tuser width (>=1); bit 0 is the error flag
- LEN_WIDTH, 16, byte-length counter and cfg_max_len width
- COUNT_WIDTH, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  DATA/KEEP/1/1/1/ID/DEST/USER  input stream
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  same widths  output stream
- cfg_max_len  in  LEN_WIDTH  maximum frame length in bytes; 0 = unlimited
- stat_frame_count  out  COUNT_WIDTH  frames emitted on m_axis (tlast beats accepted)
- stat_trunc_count  out  COUNT_WIDTH  frames truncated
- stat_last_len  out  LEN_WIDTH  byte length of the last input frame fully consumed

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - m_axis_tvalid=0 and s_axis_tready=0 while rst=1.
  - All stat outputs = 0, state=PASS, byte counter=0, skid buffer empty.
  - s_axis_tready rises on the first cycle after rst deasserts.
  - Reset mid-frame abandons that frame; the next beat accepted is treated as a frame start.
- Beat bytes = popcount(tkeep). A beat is counted only on s_axis_tvalid && s_axis_tready.
- Limit capture: the limit used for a frame is cfg_max_len captured on the frame's first beat. A mid-frame change of cfg_max_len has no effect until the next frame.
- run = byte_cnt + beat_bytes, computed at LEN_WIDTH+1 bits. byte_cnt saturates at all-ones.
- State PASS:
  - s_axis_tready = skid buffer not full.
  - Accepted beat with (limit==0 || run<=limit): forwarded unchanged. If tlast, then byte_cnt<=0, stat_last_len<=run (saturated).
  - Accepted beat with limit!=0 && run>limit: forwarded with tlast=1, tuser[0]=1, other fields unchanged; stat_trunc_count increments.
  - After a truncated beat: if the original tlast=1, then stat_last_len<=run, byte_cnt<=0 and the state stays PASS. Otherwise the state goes to DROP.
- State DROP:
  - s_axis_tready=1 regardless of m_axis_tready. Beats are discarded and nothing is emitted.
  - byte_cnt keeps accumulating.
  - On the accepted tlast beat: stat_last_len<=run, byte_cnt<=0, next state PASS.
- Output skid buffer:
  - Two entries; latency 1 cycle from input acceptance to m_axis_tvalid.
  - Full throughput of 1 beat/cycle when m_axis_tready=1.
  - m_axis payload stays stable while tvalid && !tready.
- Counter rules:
  - stat_frame_count increments on each m_axis tlast handshake.
  - All stat counters saturate at all-ones and never wrap.
- Granularity: truncation is at beat level; tkeep is never modified.
- Simultaneous events: an input accept and an output drain in the same cycle keep the buffer occupancy unchanged.

Decomposition:
- Shared package/header holds:
  - State encodings ST_PASS=1'b0 and ST_DROP=1'b1.
  - Popcount function for tkeep.
  - Error-bit index localparam USER_ERR_BIT=0.
- Sub-module axis_skid_buffer, parameterised by total payload width, carrying {tdata,tkeep,tlast,tid,tdest,tuser}.
- Length/FSM logic stays in the top module.

Test Plan:
- Setup: DATA_WIDTH=64, cfg_max_len=0. Three frames of 3 full beats each, m_axis_tready=1.
  Required: identical output one cycle later, no bubbles, stat_frame_count=3, stat_last_len=24.
- Setup: cfg_max_len=16. Frame of 4 full beats (32 bytes).
  Required: output is 3 beats, third beat has tlast=1 and tuser[0]=1. Beat 4 is consumed and dropped. stat_trunc_count=1, stat_last_len=32. A following 8-byte frame passes unchanged.
- Setup: cfg_max_len=20. Frame of 2 full beats plus a final beat with tkeep=8'h0F (20 bytes).
  Required: the frame passes intact, tuser[0]=0, stat_trunc_count=0.
- Setup: m_axis_tready toggles randomly 50% with continuous input.
  Required: no beat lost or duplicated, payload stable while stalled, s_axis_tready=0 only when the buffer is full.
- Setup: cfg_max_len changed from 8 to 0 during the second beat of a 24-byte frame.
  Required: truncation occurs at beat 2, since the limit captured at frame start (8) applies. The next frame is unlimited.
- Setup: rst asserted for 1 cycle mid-frame.
  Required: m_axis_tvalid=0 and all stats=0 the next cycle, and s_axis_tready=1 on the cycle after rst deasserts. A new frame then forwards normally.
